// File: rtl/uart_tx_engine.sv
// UART serial transmitter: valid/ready byte in, framed serial line out.
// Frame = start, DATA_WIDTH bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_engine #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_serial,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    parity_q, parity_d;
    logic                    tx_serial_q, tx_serial_d;
    logic                    tx_done_q, tx_done_d;
    logic                    bit_end;

    // State register and datapath flops
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tx_serial_q <= 1'b1;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tx_serial_q <= tx_serial_d;
            tx_done_q   <= tx_done_d;
        end
    end

    // Next-state, baud/bit counting and registered line value
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_done_d = 1'b0;
        bit_end   = (cnt_q == CNT_LAST);
        cnt_d     = bit_end ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (tx_valid) begin
                    shift_d  = tx_data;
                    parity_d = (^tx_data) ^ (PARITY_ODD != 0);
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                // idx reused to count stop bits
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d     = '0;
                        state_d   = S_IDLE;
                        tx_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;

        // Line value registered from the state being entered
        case (state_d)
            S_START:  tx_serial_d = 1'b0;
            S_DATA:   tx_serial_d = shift_d[0];
            S_PARITY: tx_serial_d = parity_d;
            default:  tx_serial_d = 1'b1;
        endcase
    end

    assign tx_ready  = (state_q == S_IDLE);
    assign tx_busy   = ~tx_ready;
    assign tx_serial = tx_serial_q;
    assign tx_done   = tx_done_q;

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- UART serial transmitter: the transmit end of the team's UART link, the counterpart of the receiver control/data path.
- Accepts a parallel byte over a valid/ready handshake and serialises it as start bit, DATA_WIDTH data bits (LSB first), optional parity bit, then 1 or 2 stop bits.
- Contains its own baud-rate divider, so no external bit-rate tick is needed.
- Output drives the receiver's rx_data_signal line directly.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range ≥ 2.
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- PARITY_EN, 1, 1 inserts a parity bit after the data bits; 0 omits it.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity. Ignored when PARITY_EN = 0.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clock, input, 1, system clock; all logic is rising-edge.
- reset, input, 1, asynchronous, active-high reset.
- tx_data, input, DATA_WIDTH, byte to send; sampled only on acceptance.
- tx_valid, input, 1, request to send tx_data.
- tx_ready, output, 1, high when a new byte can be accepted.
- tx_serial, output, 1, serial line; idles high; registered.
- tx_busy, output, 1, high while a frame is in progress.
- tx_done, output, 1, one-cycle pulse at the end of each frame.

Behaviour:
- Reset values (asynchronous, take effect immediately): tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- tx_ready = (state==IDLE), decoded from state; tx_busy = !tx_ready.
- Acceptance: tx_valid && tx_ready at a rising edge.
  - tx_data is latched into the shift register.
  - Parity is computed from the latched data: XOR of all bits, inverted when PARITY_ODD=1.
  - State moves to START.
  - tx_data and tx_valid are ignored while busy; tx_data changes after acceptance do not affect the frame.
- States:
  - IDLE: tx_serial=1.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_serial=shift[0]. Each bit is held CLKS_PER_BIT cycles, then the register shifts right and bit index increments. After bit DATA_WIDTH-1, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: tx_serial=parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx_serial=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
  - Cleared on acceptance and on every state change.
- Timing:
  - tx_serial falls in the cycle after the acceptance edge.
  - Frame length on the line = CLKS_PER_BIT*(1+DATA_WIDTH+PARITY_EN+STOP_BITS) cycles.
- tx_done:
  - Registered pulse high for exactly one cycle, coincident with the first IDLE cycle after the final stop bit.
  - tx_ready rises in that same cycle.
- Back-to-back frames:
  - A byte may be accepted on the first IDLE cycle, i.e. while tx_done is high.
  - Minimum gap between frames is therefore 1 clock of idle-high beyond the stop bits.
- tx_valid held high continuously produces frames separated by that 1-cycle gap.
- Reset mid-frame: line goes high immediately and the frame is abandoned; no tx_done pulse. The first frame after reset release is sent normally.
- Bit counter is sized as clog2(DATA_WIDTH) and wraps only via state exit; it is never compared beyond DATA_WIDTH-1.

Test Plan:
- Even parity, byte 0xA5 (CLKS_PER_BIT=4, DATA_WIDTH=8, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=1): send 0xA5.
  - Line sequence per 4-cycle bit: 0 | 1,0,1,0,0,1,0,1 | parity 0 | stop 1.
  - Total 44 cycles; tx_done pulses once at cycle 45 after acceptance.
- Odd parity, byte 0xA5 (PARITY_ODD=1): parity bit = 1. Even parity, byte 0x07: parity bit = 1.
- No parity, two stop bits (PARITY_EN=0, STOP_BITS=2), byte 0x00:
  - Line low for 36 cycles (start + 8 data bits), then high for 8 cycles.
  - Frame is 44 cycles.
- Back-to-back: tx_valid held high with 0x55 then 0xAA.
  - Second start bit begins exactly 1 cycle after the first frame's tx_done cycle.
  - tx_data changes mid-frame do not corrupt the first frame.
- Reset asserted during data bit 3.
  - tx_serial=1, tx_ready=1 and tx_busy=0 in the same cycle; no tx_done.
  - After release, 0x3C transmits correctly.
- Loopback: connect tx_serial to the receiver path and send 0x00, 0xFF, 0x81.
  - Receiver reports matching data, parity pass and stop pass for each byte.
